// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus arbiter.
package cdb_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  // Requester slots on the CDB; the ALU must stay at index 0.
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MUL = 1;
  localparam int unsigned REQ_DIV = 2;
  localparam int unsigned REQ_AGU = 3;

  // Side-band flags that travel with an ALU result.
  typedef struct packed {
    logic branch;
    logic branch_taken;
    logic jalr;
    logic store_pc;
  } cdb_flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority one-hot picker with a fixed index-0 override.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             override,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [PTR_W-1:0] cand;

  // Override wins outright; otherwise scan from ptr upward, first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (override && req[0]) begin
      gnt[0]  = 1'b1;
      gnt_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = PTR_W'((32'(ptr) + k) % N_REQ);
        if (!gnt_any && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          gnt_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle and
// broadcasts it on registered CDB fields the following cycle.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    alu_branch,
  input  logic                    alu_branch_taken,
  input  logic                    alu_jalr,
  input  logic                    alu_store_pc,
  output logic [N_REQ-1:0]        gnt,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic                    cdb_branch,
  output logic                    cdb_branch_taken,
  output logic                    cdb_jalr,
  output logic                    cdb_store_pc
);

  import cdb_pkg::*;

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  cdb_flags_t        flags_q, flags_d;
  cdb_flags_t        alu_flags;

  logic              override;
  logic [N_REQ-1:0]  pick;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  // Dispatch stalls on branch/JALR resolution, so those ALU results jump the queue.
  assign override = req[REQ_ALU] & (alu_branch | alu_jalr);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req      (req),
    .ptr      (ptr_q),
    .override (override),
    .gnt      (pick),
    .gnt_idx  (pick_idx),
    .gnt_any  (pick_any)
  );

  assign gnt = rst ? pick : '0;

  // ALU flags as broadcast; taken is meaningless without a branch.
  always_comb begin
    alu_flags              = '0;
    alu_flags.branch       = alu_branch;
    alu_flags.branch_taken = alu_branch & alu_branch_taken;
    alu_flags.jalr         = alu_jalr;
    alu_flags.store_pc     = alu_store_pc;
  end

  // Next pointer and next bus contents; an idle bus is all zero.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    tag_d   = '0;
    data_d  = '0;
    flags_d = '0;
    if (pick_any) begin
      ptr_d   = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      valid_d = 1'b1;
      tag_d   = req_tag[pick_idx*TAG_W +: TAG_W];
      data_d  = req_data[pick_idx*DATA_W +: DATA_W];
      if (pick_idx == PTR_W'(REQ_ALU)) begin
        flags_d = alu_flags;
      end
    end
  end

  // Pointer and CDB output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign cdb_valid        = valid_q;
  assign cdb_tag          = tag_q;
  assign cdb_data         = data_q;
  assign cdb_branch       = flags_q.branch;
  assign cdb_branch_taken = flags_q.branch_taken;
  assign cdb_jalr         = flags_q.jalr;
  assign cdb_store_pc     = flags_q.store_pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued when a
// grant is modelled and compared on the following cycle.
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [3:0]    fl;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*TW-1:0]   req_tag = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              alu_branch = 1'b0, alu_branch_taken = 1'b0;
  logic              alu_jalr = 1'b0, alu_store_pc = 1'b0;
  logic [N-1:0]      gnt;
  logic              cdb_valid, cdb_branch, cdb_branch_taken, cdb_jalr, cdb_store_pc;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;

  cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
    .alu_branch(alu_branch), .alu_branch_taken(alu_branch_taken),
    .alu_jalr(alu_jalr), .alu_store_pc(alu_store_pc), .gnt(gnt),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
    .cdb_jalr(cdb_jalr), .cdb_store_pc(cdb_store_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  // Bench-side requester state.
  logic          pend [N];
  logic [TW-1:0] ptag [N];
  logic [DW-1:0] pdata[N];
  int            waitc[N];
  logic          a_br = 0, a_bt = 0, a_j = 0, a_sp = 0;
  int            mptr = 0;
  logic [N-1:0]  last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int model_pick(input int p);
    int i;
    if (pend[0] && (a_br || a_j)) return 0;
    i = p;
    repeat (N) begin
      if (pend[i]) return i;
      i = (i == N - 1) ? 0 : i + 1;
    end
    return -1;
  endfunction

  task automatic check_cdb();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
      chk("cdb_tag",   64'(cdb_tag),   64'(e.tag));
      chk("cdb_data",  64'(cdb_data),  64'(e.data));
      chk("cdb_flags", 64'({cdb_branch, cdb_branch_taken, cdb_jalr, cdb_store_pc}), 64'(e.fl));
    end
  endtask

  // One clock: compare last broadcast, drive requests, check grant, queue expectation.
  task automatic tick(input bit fair_chk);
    int idx;
    exp_t e;
    @(negedge clk);
    check_cdb();
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i];
      req_tag[i*TW +: TW] = ptag[i];
      req_data[i*DW +: DW] = pdata[i];
    end
    alu_branch = a_br; alu_branch_taken = a_bt; alu_jalr = a_j; alu_store_pc = a_sp;
    #1;
    idx = model_pick(mptr);
    e = '0;
    if (idx >= 0) begin
      e.v = 1'b1; e.tag = ptag[idx]; e.data = pdata[idx];
      if (idx == 0) e.fl = {a_br, a_br & a_bt, a_j, a_sp};
      chk("gnt", 64'(gnt), 64'(1 << idx));
      pend[idx] = 1'b0;
      mptr = (idx + 1) % N;
    end else begin
      chk("gnt_idle", 64'(gnt), 64'd0);
    end
    exp_q.push_back(e);
    last_gnt = gnt;
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i] || !req[i]) waitc[i] = 0;
      else waitc[i]++;
      if (fair_chk && req[i]) chk("fair_wait", 64'(waitc[i] > N - 1), 64'd0);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; ptag[i] = '0; pdata[i] = '0; waitc[i] = 0;
    end
    a_br = 0; a_bt = 0; a_j = 0; a_sp = 0;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    pend[i] = 1'b1; ptag[i] = t; pdata[i] = d; waitc[i] = 0;
  endtask

  // Release reset at a negedge with idle inputs; the first sample is an idle bus.
  task automatic release_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    mptr = 0;
    exp_q.push_back('0);
  endtask

  // Drop reset in the middle of a cycle that is showing a broadcast.
  task automatic reset_mid_broadcast();
    set_req(1, 6'h2a, 32'hcafe_0001);
    tick(0);
    @(negedge clk);
    check_cdb();
    req = 4'b0100;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(cdb_valid), 64'd0);
    chk("rst_mid_tag",   64'(cdb_tag),   64'd0);
    chk("rst_mid_data",  64'(cdb_data),  64'd0);
    chk("rst_mid_gnt",   64'(gnt),       64'd0);
    exp_q.delete();
    clear_all();
    release_reset();
  endtask

  initial begin
    clear_all();
    // Reset with every requester active: grant held off, bus zero.
    req = '1;
    req_tag = '1;
    req_data = '1;
    alu_branch = 1; alu_jalr = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_cdb", 64'({cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken,
                          cdb_jalr, cdb_store_pc}), 64'd0);
    end
    release_reset();

    // Idle.
    repeat (3) tick(0);

    // Single MUL request.
    set_req(1, 6'h05, 32'h0000_1234);
    tick(0);

    // ptr=2: DIV, AGU and a JALR on the ALU; the ALU goes first.
    set_req(2, 6'h11, 32'h2222_0000);
    set_req(3, 6'h12, 32'h3333_0000);
    set_req(0, 6'h13, 32'h0040_0100);
    a_j = 1;
    tick(0);
    a_j = 0;
    tick(0);
    tick(0);

    // Not-taken branch; stray taken without branch; stray flags on an AGU grant.
    set_req(0, 6'h20, 32'h0000_0a0a);
    a_br = 1; a_bt = 0;
    tick(0);
    set_req(0, 6'h21, 32'h0000_0b0b);
    a_br = 0; a_bt = 1; a_sp = 1;
    tick(0);
    set_req(3, 6'h22, 32'h0000_0c0c);
    a_br = 1; a_bt = 1; a_j = 1; a_sp = 1;
    tick(0);
    a_br = 0; a_bt = 0; a_j = 0; a_sp = 0;

    // Put ptr at 2, then MUL competes with everyone and must wait 3 cycles.
    set_req(1, 6'h30, 32'h0000_0030);
    tick(0);
    set_req(1, 6'h31, 32'hbeef_0031);
    set_req(0, 6'h32, 32'h0000_0032);
    set_req(2, 6'h33, 32'h0000_0033);
    set_req(3, 6'h34, 32'h0000_0034);
    repeat (4) tick(1);
    chk("mul_wait_done", 64'(pend[1]), 64'd0);

    // Reset mid-broadcast, then all four requesting back-to-back from ptr=0.
    reset_mid_broadcast();
    for (int i = 0; i < N; i++) set_req(i, TW'(i << 4), 32'h1000_0000 + 32'(i));
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk("rr_order", 64'(last_gnt), 64'(1 << (c % N)));
      for (int i = 0; i < N; i++)
        if (!pend[i]) set_req(i, TW'((i << 4) | (c + 1)), 32'h1000_0000 + 32'(c * 16 + i));
    end

    // Random traffic without override: bounded waiting.
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 9) < 7)
          set_req(i, TW'($urandom), $urandom);
      if (!pend[0]) a_sp = 1'($urandom);
      tick(1);
    end

    // Random traffic including branch/JALR overrides.
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 9) < 6)
          set_req(i, TW'($urandom), $urandom);
      if (!pend[0]) begin
        a_br = 1'($urandom); a_bt = 1'($urandom);
        a_j = 1'($urandom_range(0, 3) == 0); a_sp = 1'($urandom);
      end
      tick(0);
    end

    // Drain the last broadcast.
    clear_all();
    tick(0);
    @(negedge clk);
    check_cdb();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) among the four execution units (ALU, MUL, DIV, AGU/load). Each cycle it grants at most one pending result and drives it onto the registered CDB fields one cycle later. Those fields feed the dispatch unit's register file, register status table, tag FIFO, staller and the queue wake-up logic. Scheduling is round-robin, with a fixed override so ALU branch and JALR resolutions are never delayed, because dispatch is stalled on them.

## Interface
Parameters:
- N_REQ, 4, number of requesters; index 0 is always the ALU.
- DATA_W, 32, result width.
- TAG_W, 6, rename tag width.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous, active-low reset.
- req, in, N_REQ, per-unit result pending.
- req_tag, in, N_REQ×TAG_W, per-unit destination tag.
- req_data, in, N_REQ×DATA_W, per-unit result data.
- alu_branch, in, 1, ALU result is a resolved conditional branch.
- alu_branch_taken, in, 1, the resolved branch is taken.
- alu_jalr, in, 1, ALU result is a JALR target.
- alu_store_pc, in, 1, register file must take PC+4 from the PC queue.
- gnt, out, N_REQ, one-hot grant for the current cycle.
- cdb_valid, out, 1, CDB carries a result.
- cdb_tag, out, TAG_W, tag of the broadcast result.
- cdb_data, out, DATA_W, data of the broadcast result.
- cdb_branch, out, 1, broadcast is a branch resolution.
- cdb_branch_taken, out, 1, the branch is taken.
- cdb_jalr, out, 1, broadcast is a JALR target.
- cdb_store_pc, out, 1, broadcast writes PC+4.
- The cdb_* outputs drive cdb_if at the top level.

## Operation
- Requester handshake: a unit holds req high with stable tag and data (plus ALU flags) until it samples gnt high at a rising edge. It may present a new result in the cycle after the grant.
- Grant rule: gnt is combinational from req and the pointer ptr, and is at most one-hot.
  - Override: if req[0] is high and (alu_branch or alu_jalr), grant index 0.
  - Otherwise grant the first requesting index scanning ptr, ptr+1, … modulo N_REQ.
  - No request gives gnt = 0.
- ptr update on any grant to index i: ptr ← (i+1) mod N_REQ. This also applies to override grants. With no grant, ptr holds.
- Output register on each edge:
  - If a grant occurred: cdb_valid←1, and tag and data load from the granted index.
  - If index 0 was granted, the flags load from the alu_* inputs. For any other index, the flags load 0.
  - With no grant, all cdb_* outputs load 0 (the bus is zero when idle).
- cdb_branch_taken is forced to 0 whenever alu_branch is 0.
- ALU flag inputs are ignored unless req[0] is high.
- Requests dropped without a grant are legal. Nothing is latched until the grant.

## Timing
- Reset (rst low, asynchronous): ptr=0 and every cdb_* output is 0. gnt is forced to 0 while rst is low.
- Reset asserted mid-operation discards the in-flight broadcast on the same edge with no pending residue. The first grant after release follows ptr=0.
- Latency: a grant in cycle T produces the broadcast in cycle T+1, valid for exactly one cycle.
- Throughput: one result per cycle, back-to-back. A lone requester may be granted every cycle.
- Fairness: without override traffic, a waiting requester is granted within N_REQ−1 cycles. Override traffic can delay it, but only while consecutive ALU branch or JALR results are pending.
- Wrap-around: ptr runs 3→0 for N_REQ=4.
- All four requests in one cycle: exactly one grant, and the other requesters keep req held.

## Structure
- Shared package cdb_pkg:
  - TAG_W and DATA_W.
  - Requester index constants REQ_ALU=0, REQ_MUL=1, REQ_DIV=2, REQ_AGU=3.
  - A packed struct cdb_flags_t holding branch, branch_taken, jalr and store_pc.
- One sub-module, rr_arbiter: a combinational rotating-priority one-hot picker taking req, ptr and override and returning gnt and the granted index.
- ptr and the output register live in cdb_arbiter.

## Test plan
- Reset then idle: req=0000 → gnt=0000 and every cdb_* output is 0 on every cycle; rst low mid-broadcast → cdb_valid drops to 0 immediately.
- Single MUL request, tag 6'h05, data 32'h1234 → gnt=0010 in cycle T; in T+1, cdb_valid=1, cdb_tag=05, cdb_data=1234, all flags 0; ptr=2.
- All four requesting continuously from reset → grant order ALU, MUL, DIV, AGU, ALU…; each appears on the CDB one cycle later.
- Starting from ptr=2 with DIV, AGU and ALU requesting, where the ALU has alu_jalr=1 and data 32'h00400100 → ALU granted first; next cdb_jalr=1 and cdb_data=00400100; ptr=1.
- ALU branch with alu_branch=1 and alu_branch_taken=0 → cdb_branch=1 and cdb_branch_taken=0. AGU granted with stray alu_* flags high but req[0]=0 → all broadcast flags 0.
- MUL holds req for 3 cycles while ALU, DIV and AGU compete → MUL granted within 3 cycles, and its tag and data are unchanged on the CDB.
